// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bundle: redirect, imem request/response, decode output
interface fetch_unit_if;
   logic        pc_update_control;
   logic [31:0] pc_update_val;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        if_valid;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
   logic        if_ready;

   modport master (
      input  pc_update_control, pc_update_val,
      input  imem_req_ready, imem_resp_valid, imem_resp_data,
      input  if_ready,
      output imem_req_valid, imem_req_addr,
      output if_valid, if_inst, if_pc
   );

   modport slave (
      output pc_update_control, pc_update_val,
      output imem_req_ready, imem_resp_valid, imem_resp_data,
      output if_ready,
      input  imem_req_valid, imem_req_addr,
      input  if_valid, if_inst, if_pc
   );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - credit-limited instruction fetch with redirect flush and response discard
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic          i_clk,
   input  logic          i_rst,
   fetch_unit_if.master  bus
);
   localparam int CW = $clog2(BUF_DEPTH + 1);
   localparam int AW = $clog2(BUF_DEPTH);

   typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

   state_t        state, state_nxt;
   logic [31:0]   fetch_pc, resp_pc;
   logic [CW-1:0] inflight, drop, count, drop_nxt;
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [31:0]   mem_pc   [BUF_DEPTH];
   logic [31:0]   mem_inst [BUF_DEPTH];

   logic        redirect, req_valid, req_fire, push, pop;
   logic [31:0] target;

   assign target   = {bus.pc_update_val[31:2], 2'b00};
   assign redirect = bus.pc_update_control && (state != BOOT);
   assign req_fire = req_valid && bus.imem_req_ready;
   // a response landing in the redirect cycle belongs to the old stream
   assign push     = bus.imem_resp_valid && (drop == '0) && !redirect;
   assign pop      = bus.if_valid && bus.if_ready;

   always_comb begin
      state_nxt = state;
      req_valid = 1'b0;
      drop_nxt  = drop;
      case (state)
         BOOT:    state_nxt = RUN;
         RUN:     req_valid = ((int'(inflight) + int'(count)) < BUF_DEPTH) && !bus.pc_update_control;
         DRAIN:   req_valid = 1'b0;
         default: state_nxt = BOOT;
      endcase
      if (redirect) begin
         drop_nxt = inflight - CW'(bus.imem_resp_valid);
      end else if (bus.imem_resp_valid && (drop != '0)) begin
         drop_nxt = drop - CW'(1);
      end
      if (state != BOOT) begin
         state_nxt = (drop_nxt != '0) ? DRAIN : RUN;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state    <= BOOT;
         fetch_pc <= RESET_PC;
         resp_pc  <= RESET_PC;
         inflight <= '0;
         drop     <= '0;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else begin
         state    <= state_nxt;
         drop     <= drop_nxt;
         inflight <= inflight + CW'(req_fire) - CW'(bus.imem_resp_valid);
         if (redirect) begin
            fetch_pc <= target;
            resp_pc  <= target;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
         end else begin
            if (req_fire) begin
               fetch_pc <= fetch_pc + 32'd4;
            end
            if (push) begin
               resp_pc <= resp_pc + 32'd4;
               wr_ptr  <= wr_ptr + AW'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   // storage needs no reset: outputs are masked while count is zero
   always_ff @(posedge i_clk) begin
      if (push) begin
         mem_pc[wr_ptr]   <= resp_pc;
         mem_inst[wr_ptr] <= bus.imem_resp_data;
      end
   end

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = fetch_pc;
   assign bus.if_valid       = (count != '0) && !bus.pc_update_control;
   assign bus.if_inst        = (count != '0) ? mem_inst[rd_ptr] : 32'd0;
   assign bus.if_pc          = (count != '0) ? mem_pc[rd_ptr]   : 32'd0;
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - table-driven and randomized checks of fetch_unit against a queue-based model
module tb_fetch_unit;
   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam int          DEPTH  = 2;

   logic i_clk = 1'b0;
   logic i_rst = 1'b0;

   fetch_unit_if bus ();

   fetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus)
   );

   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct { logic [31:0] addr; bit stale; } req_t;
   typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
   typedef struct { int due; logic [31:0] data; } rsp_t;

   req_t        m_infl[$];
   ent_t        m_fifo[$];
   rsp_t        mem_q[$];
   bit          m_boot;
   logic [31:0] m_fpc;
   int          cyc;
   int          lat;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   function automatic bit any_stale();
      foreach (m_infl[i]) if (m_infl[i].stale) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic drive_idle();
      bus.pc_update_control = 1'b0;
      bus.pc_update_val     = 32'd0;
      bus.if_ready          = 1'b0;
      bus.imem_req_ready    = 1'b0;
      bus.imem_resp_valid   = 1'b0;
      bus.imem_resp_data    = 32'd0;
   endtask

   // Asynchronous reset assert mid-cycle; memory model is reset alongside
   task automatic do_reset(input int l);
      @(negedge i_clk);
      drive_idle();
      #2 i_rst = 1'b0;
      #1;
      check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check("rst_req_addr",  bus.imem_req_addr, RST_PC);
      check("rst_if_valid",  32'(bus.if_valid), 32'd0);
      check("rst_if_pc",     bus.if_pc, 32'd0);
      check("rst_if_inst",   bus.if_inst, 32'd0);
      m_infl.delete();
      m_fifo.delete();
      mem_q.delete();
      m_boot = 1'b1;
      m_fpc  = RST_PC;
      lat    = l;
      cyc    = 0;
      @(posedge i_clk);
      #2 i_rst = 1'b1;
   endtask

   // One clock cycle: drive, compare against the model, then advance the model
   task automatic tick(input bit redir, input logic [31:0] tgt, input bit rdy, input bit qrdy,
                       output bit delivered, output logic [31:0] dpc);
      bit          rv, e_rv, e_iv;
      logic [31:0] rd, e_pc, e_inst;
      req_t        r;
      @(negedge i_clk);
      rv = (mem_q.size() > 0) && (mem_q[0].due == cyc);
      rd = rv ? mem_q[0].data : $urandom();
      bus.pc_update_control = redir;
      bus.pc_update_val     = tgt;
      bus.if_ready          = rdy;
      bus.imem_req_ready    = qrdy;
      bus.imem_resp_valid   = rv;
      bus.imem_resp_data    = rd;
      #1;
      e_rv   = !m_boot && !redir && !any_stale() && ((m_infl.size() + m_fifo.size()) < DEPTH);
      e_iv   = (m_fifo.size() > 0) && !redir;
      e_pc   = (m_fifo.size() > 0) ? m_fifo[0].pc   : 32'd0;
      e_inst = (m_fifo.size() > 0) ? m_fifo[0].inst : 32'd0;
      check("req_valid", 32'(bus.imem_req_valid), 32'(e_rv));
      check("req_addr",  bus.imem_req_addr, m_fpc);
      check("if_valid",  32'(bus.if_valid), 32'(e_iv));
      check("if_pc",     bus.if_pc, e_pc);
      check("if_inst",   bus.if_inst, e_inst);
      delivered = bus.if_valid && rdy;
      dpc       = bus.if_pc;
      @(posedge i_clk);
      if (m_boot) begin
         m_boot = 1'b0;
      end else begin
         if (e_iv && rdy) void'(m_fifo.pop_front());
         if (rv) begin
            void'(mem_q.pop_front());
            if (m_infl.size() > 0) begin
               r = m_infl.pop_front();
               if (!r.stale && !redir) m_fifo.push_back('{r.addr, mem_word(r.addr)});
            end
         end
         if (redir) begin
            m_fifo.delete();
            foreach (m_infl[i]) m_infl[i].stale = 1'b1;
            m_fpc = {tgt[31:2], 2'b00};
         end else if (e_rv && qrdy) begin
            m_infl.push_back('{m_fpc, 1'b0});
            mem_q.push_back('{cyc + lat, mem_word(m_fpc)});
            m_fpc = m_fpc + 32'd4;
         end
      end
      cyc++;
   endtask

   typedef struct {
      string       name;
      int          lat;
      int          stall_at;
      int          stall_len;
      int          r1_at;
      logic [31:0] r1;
      int          r2_at;
      logic [31:0] r2;
      logic [31:0] exp_first;
      logic [31:0] exp_second;
   } vec_t;

   initial begin
      vec_t        vecs[7];
      bit          dl;
      logic [31:0] dp;
      int          seen;
      logic [31:0] got1, got2;

      vecs[0] = '{"seq",       1, 1000, 0, -1, 32'h0,         -1, 32'h0,   32'h100,       32'h104};
      vecs[1] = '{"stall",     1, 0,    6, -1, 32'h0,         -1, 32'h0,   32'h100,       32'h104};
      vecs[2] = '{"redir2",    3, 1000, 0,  3, 32'h400,       -1, 32'h0,   32'h400,       32'h404};
      vecs[3] = '{"redirresp", 1, 1000, 0,  2, 32'h400,       -1, 32'h0,   32'h400,       32'h404};
      vecs[4] = '{"b2b",       2, 1000, 0,  3, 32'h200,        4, 32'h300, 32'h300,       32'h304};
      vecs[5] = '{"misalign",  1, 1000, 0,  4, 32'h203,       -1, 32'h0,   32'h200,       32'h204};
      vecs[6] = '{"wrap",      1, 1000, 0,  4, 32'hFFFF_FFFC, -1, 32'h0,   32'hFFFF_FFFC, 32'h0};

      drive_idle();
      for (int v = 0; v < 7; v++) begin
         do_reset(vecs[v].lat);
         seen = 0;
         got1 = 32'hDEAD_DEAD;
         got2 = 32'hDEAD_DEAD;
         for (int c = 0; c < 40; c++) begin
            bit          rd_n;
            logic [31:0] tg;
            rd_n = (c == vecs[v].r1_at) || (c == vecs[v].r2_at);
            tg   = (c == vecs[v].r2_at) ? vecs[v].r2 : vecs[v].r1;
            tick(rd_n, tg, !(c >= vecs[v].stall_at && c < vecs[v].stall_at + vecs[v].stall_len),
                 1'b1, dl, dp);
            if (dl && c > vecs[v].r1_at) begin
               if (seen == 0) got1 = dp;
               if (seen == 1) got2 = dp;
               seen++;
            end
         end
         check({vecs[v].name, "_first_pc"},  got1, vecs[v].exp_first);
         check({vecs[v].name, "_second_pc"}, got2, vecs[v].exp_second);
      end

      // Reset while draining: outputs clear at once, BOOT then a fresh request at RESET_PC
      do_reset(3);
      for (int c = 0; c < 5; c++) tick(c == 3, 32'h800, 1'b1, 1'b1, dl, dp);
      do_reset(3);
      tick(1'b0, 32'h0, 1'b1, 1'b1, dl, dp);
      check("boot_no_req", 32'(bus.imem_req_valid), 32'd0);
      tick(1'b0, 32'h0, 1'b1, 1'b1, dl, dp);
      for (int c = 0; c < 10; c++) tick(1'b0, 32'h0, 1'b1, 1'b1, dl, dp);

      // Randomized segments with per-segment memory latency
      for (int s = 0; s < 4; s++) begin
         do_reset($urandom_range(1, 4));
         for (int c = 0; c < 500; c++) begin
            tick($urandom_range(0, 9) == 0, $urandom(), $urandom_range(0, 9) < 7,
                 $urandom_range(0, 3) != 0, dl, dp);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end
endmodule
